// File: rtl/shiftregister_rx_pkg.sv
// Shared definitions for the shiftregister_rx serial receiver:
// default word width, counter-width helper and holding-register state encoding.
package shiftregister_rx_pkg;

  localparam int N_DEFAULT = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/shiftregister_rx_sipo_core.sv
// Serial-in/parallel-out core: MSB-first shift register plus bit counter,
// pulsing word_done on the strobe that carries the last bit of a word.
module sipo_core
  import shiftregister_rx_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int CNT_W = clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             si,
  input  logic             clr,
  output logic [N-1:0]     word,
  output logic             word_done,
  output logic [CNT_W-1:0] bitcnt
);

  logic [N-1:0]     sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // word is the shift result of this edge, so it already includes the incoming bit.
  assign word   = {sh_q[N-2:0], si};
  assign bitcnt = cnt_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    if (clr) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (en) begin
      sh_d = word;
      if (cnt_q == CNT_W'(N - 1)) begin
        cnt_d     = '0;
        word_done = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    if (!rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shiftregister_rx.sv
// Serial-to-parallel receiver: sipo_core feeds a one-deep holding register
// with a valid/ready handshake and a sticky overrun flag.
module shiftregister_rx
  import shiftregister_rx_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int CNT_W = clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             si,
  input  logic             clr,
  output logic [N-1:0]     dout,
  output logic             valid,
  input  logic             ready,
  output logic             ovf,
  output logic [CNT_W-1:0] bitcnt
);

  logic [N-1:0] word;
  logic         word_done;

  hold_state_e  state_q, state_d;
  logic [N-1:0] dout_q, dout_d;
  logic         ovf_q, ovf_d;

  sipo_core #(.N(N), .CNT_W(CNT_W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .si        (si),
    .clr       (clr),
    .word      (word),
    .word_done (word_done),
    .bitcnt    (bitcnt)
  );

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    case (state_q)
      EMPTY: begin
        if (word_done) begin
          dout_d  = word;
          state_d = FULL;
        end
      end
      FULL: begin
        if (ready) begin
          // A word consumed on the same edge a new one completes refills the slot.
          if (word_done) dout_d = word;
          else           state_d = EMPTY;
        end else if (word_done) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout  = dout_q;
  assign valid = (state_q == FULL);
  assign ovf   = ovf_q;

endmodule
